// File: rtl/uart_tx_core_if.sv
// Parallel-side handshake and serial outputs of the UART transmitter.
// The data source drives through master; the transmitter core connects through slave.
interface uart_tx_core_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic [DATA_WIDTH-1:0]     p_data;
  logic                      data_valid;
  logic                      par_en;
  logic                      par_typ;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      tx_out;
  logic                      busy;

  modport master (
    output p_data, data_valid, par_en, par_typ, prescale,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, prescale,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_core #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_core_if.slave  bus
);
  localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] edge_last;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
  logic [DATA_WIDTH-1:0]     shreg;
  logic                      par_bit;
  logic                      par_en_q;
  logic                      tx_q;
  logic                      busy_q;
  logic                      bit_done;
`ifdef UART_TX_TWO_STOP_EN
  logic                      stop_idx;
`endif

  assign bit_done   = (edge_cnt == edge_last);
  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

  // edge_last holds P-1 so a PRESCALE of 0 behaves exactly like 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      edge_cnt  <= '0;
      edge_last <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      par_en_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_idx  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_q     <= 1'b1;
          busy_q   <= 1'b0;
          edge_cnt <= '0;
          bit_cnt  <= '0;
          if (bus.data_valid) begin
            state     <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            shreg     <= bus.p_data;
            par_en_q  <= bus.par_en;
            par_bit   <= (^bus.p_data) ^ bus.par_typ;
            edge_last <= (bus.prescale == '0) ? '0
                                              : bus.prescale - PRESCALE_WIDTH'(1);
          end
        end

        START: begin
          if (bit_done) begin
            edge_cnt <= '0;
            state    <= DATA;
            tx_q     <= shreg[0];
            shreg    <= shreg >> 1;
          end else begin
            edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            edge_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (par_en_q) begin
                state <= PAR;
                tx_q  <= par_bit;
              end else begin
                state <= STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_WIDTH'(1);
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
          end
        end

        PAR: begin
          if (bit_done) begin
            edge_cnt <= '0;
            state    <= STOP;
            tx_q     <= 1'b1;
          end else begin
            edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
          end
        end

        STOP: begin
          if (bit_done) begin
            edge_cnt <= '0;
`ifdef UART_TX_TWO_STOP_EN
            if (!stop_idx) begin
              stop_idx <= 1'b1;
            end else begin
              stop_idx <= 1'b0;
              state    <= IDLE;
              busy_q   <= 1'b0;
              tx_q     <= 1'b1;
            end
`else
            state  <= IDLE;
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
`endif
          end else begin
            edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
          end
        end

        default: begin
          state    <= IDLE;
          tx_q     <= 1'b1;
          busy_q   <= 1'b0;
          edge_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_core.sv
// Directed testbench for uart_tx_core; expected waveforms are hand-written bit lists.
// Honours UART_TX_TWO_STOP_EN by extending the stop section of every expected frame.
module tb_uart_tx_core;
  localparam int DW = 8;
  localparam int PW = 6;
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic cap_tx   [512];
  logic cap_busy [512];

  uart_tx_core_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();

  uart_tx_core #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Presents one word for a single cycle; returns at the sample point of cycle t+1.
  task automatic start_frame(input logic [7:0] data, input logic pe, input logic pt,
                             input logic [5:0] presc);
    bus.p_data     = data;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.prescale   = presc;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
  endtask

  // Records n cycles of tx_out/busy; with disturb set, inputs churn while the frame runs.
  task automatic capture(input int n, input logic disturb);
    for (int k = 0; k < n; k++) begin
      cap_tx[k]   = bus.tx_out;
      cap_busy[k] = bus.busy;
      if (disturb && k < n - 2) begin
        bus.data_valid = k[0];
        bus.p_data     = 8'($urandom);
        bus.par_en     = ~bus.par_en;
        bus.par_typ    = ~bus.par_typ;
        bus.prescale   = 6'($urandom);
      end else begin
        bus.data_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.data_valid = 1'b0;
    bus.p_data     = '0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.prescale   = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_hold: tx_out=%b busy=%b required tx_out=1 busy=0",
               bus.tx_out, bus.busy);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release_idle: tx_out=%b busy=%b required tx_out=1 busy=0",
               bus.tx_out, bus.busy);
    end
  endtask

  task automatic test_parity_even();
    logic exp_bits[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int   p = 8;
    int   n = (10 + STOPS) * p + 1;
    logic et, eb;
    start_frame(8'hA5, 1'b1, 1'b0, 6'd8);
    capture(n, 1'b0);
    for (int k = 0; k < n; k++) begin
      et = (k / p < 10) ? exp_bits[k / p] : 1'b1;
      eb = (k < n - 1);
      checks++;
      if (cap_tx[k] !== et || cap_busy[k] !== eb) begin
        failures++;
        $display("[TB] FAIL parity_even cycle t+%0d: tx_out=%b busy=%b required %b %b",
                 k + 1, cap_tx[k], cap_busy[k], et, eb);
      end
    end
  endtask

  task automatic test_parity_odd();
    logic exp_bits[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   p = 8;
    int   n = (10 + STOPS) * p + 1;
    logic et, eb;
    start_frame(8'hA5, 1'b1, 1'b1, 6'd8);
    capture(n, 1'b0);
    for (int k = 0; k < n; k++) begin
      et = (k / p < 10) ? exp_bits[k / p] : 1'b1;
      eb = (k < n - 1);
      checks++;
      if (cap_tx[k] !== et || cap_busy[k] !== eb) begin
        failures++;
        $display("[TB] FAIL parity_odd cycle t+%0d: tx_out=%b busy=%b required %b %b",
                 k + 1, cap_tx[k], cap_busy[k], et, eb);
      end
    end
  endtask

  task automatic test_no_parity();
    logic exp_bits[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int   p = 8;
    int   n = (9 + STOPS) * p + 1;
    logic et, eb;
    start_frame(8'hFF, 1'b0, 1'b1, 6'd8);
    capture(n, 1'b0);
    for (int k = 0; k < n; k++) begin
      et = (k / p < 9) ? exp_bits[k / p] : 1'b1;
      eb = (k < n - 1);
      checks++;
      if (cap_tx[k] !== et || cap_busy[k] !== eb) begin
        failures++;
        $display("[TB] FAIL no_parity cycle t+%0d: tx_out=%b busy=%b required %b %b",
                 k + 1, cap_tx[k], cap_busy[k], et, eb);
      end
    end
  endtask

  // PRESCALE of 0 and of 1 must both give one clock per bit.
  task automatic test_min_prescale();
    logic exp_bits[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int   n = 9 + STOPS + 1;
    logic et, eb;
    for (int ps = 0; ps < 2; ps++) begin
      start_frame(8'h01, 1'b0, 1'b0, 6'(ps));
      capture(n, 1'b0);
      for (int k = 0; k < n; k++) begin
        et = (k < 9) ? exp_bits[k] : 1'b1;
        eb = (k < n - 1);
        checks++;
        if (cap_tx[k] !== et || cap_busy[k] !== eb) begin
          failures++;
          $display("[TB] FAIL min_prescale_%0d cycle t+%0d: tx_out=%b busy=%b required %b %b",
                   ps, k + 1, cap_tx[k], cap_busy[k], et, eb);
        end
      end
    end
  endtask

  task automatic test_config_latch();
    logic exp_bits[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int   p = 8;
    int   n = (10 + STOPS) * p + 1;
    logic et, eb;
    start_frame(8'hA5, 1'b1, 1'b0, 6'd8);
    capture(n, 1'b1);
    for (int k = 0; k < n; k++) begin
      et = (k / p < 10) ? exp_bits[k / p] : 1'b1;
      eb = (k < n - 1);
      checks++;
      if (cap_tx[k] !== et || cap_busy[k] !== eb) begin
        failures++;
        $display("[TB] FAIL config_latch cycle t+%0d: tx_out=%b busy=%b required %b %b",
                 k + 1, cap_tx[k], cap_busy[k], et, eb);
      end
    end
  endtask

  // data_valid stays high across the first frame, so the second starts after one idle cycle.
  task automatic test_back_to_back();
    logic seq_3c[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic seq_c3[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int   p  = 4;
    int   fc = (9 + STOPS) * p;
    int   b;
    logic et, eb;
    bus.p_data     = 8'h3C;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.prescale   = 6'd4;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.p_data = 8'hC3;
    for (int k = 0; k < 2 * fc + 2; k++) begin
      if (k < fc) begin
        b  = k / p;
        et = (b < 9) ? seq_3c[b] : 1'b1;
        eb = 1'b1;
      end else if (k == fc || k == 2 * fc + 1) begin
        et = 1'b1;
        eb = 1'b0;
      end else begin
        b  = (k - fc - 1) / p;
        et = (b < 9) ? seq_c3[b] : 1'b1;
        eb = 1'b1;
      end
      checks++;
      if (bus.tx_out !== et || bus.busy !== eb) begin
        failures++;
        $display("[TB] FAIL back_to_back cycle t+%0d: tx_out=%b busy=%b required %b %b",
                 k + 1, bus.tx_out, bus.busy, et, eb);
      end
      if (k == fc + 1) bus.data_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.data_valid = 1'b0;
  endtask

  task automatic test_abort();
    logic exp_bits[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int   n = 9 + STOPS + 1;
    logic et, eb;
    start_frame(8'hA5, 1'b1, 1'b0, 6'd8);
    repeat (29) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_pre_busy: busy=%b required 1", bus.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_async: tx_out=%b busy=%b required tx_out=1 busy=0",
               bus.tx_out, bus.busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL abort_quiet cycle %0d: tx_out=%b busy=%b required tx_out=1 busy=0",
                 k, bus.tx_out, bus.busy);
      end
    end
    start_frame(8'h01, 1'b0, 1'b0, 6'd1);
    capture(n, 1'b0);
    for (int k = 0; k < n; k++) begin
      et = (k < 9) ? exp_bits[k] : 1'b1;
      eb = (k < n - 1);
      checks++;
      if (cap_tx[k] !== et || cap_busy[k] !== eb) begin
        failures++;
        $display("[TB] FAIL abort_recover cycle t+%0d: tx_out=%b busy=%b required %b %b",
                 k + 1, cap_tx[k], cap_busy[k], et, eb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_parity_even();
    test_parity_odd();
    test_no_parity();
    test_min_prescale();
    test_config_latch();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
